tm1638_responder: RTL and testbench
===================================

Name: tm1638_responder

Overview:
- Synthesizable model of the TM1638 chip side of the serial link driven by tm1638_board_controller.
- Receives the STB/CLK/DIO command stream, maintains the 16-byte display RAM and the display-control register, and returns the four key-scan bytes on read commands.
- Used in the on-chip loopback self-test (feeding sticky_failure) and as the device model in board-controller benches.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in the input synchronizers for sio_clk, sio_stb and sio_dio_in (legal values 2 or 3).

Ports:
- clock  input  1  system clock
- reset_n  input  1  one clock; reset is asynchronous and active-low
- sio_clk  input  1  serial clock from the master; idle high
- sio_stb  input  1  strobe from the master, active low; a frame is one low period
- sio_dio_in  input  1  DIO as seen on the pad
- sio_dio_out  output  1  DIO value driven by the responder
- sio_dio_oe  output  1  responder drive enable for DIO
- keys  input  8  key states to report; 1 = pressed
- ram_addr  input  4  display RAM read address
- ram_data  output  8  display RAM byte at ram_addr; combinational read
- display_on  output  1  display-control bit 3
- brightness  output  3  display-control bits 2:0
- frame_done  output  1  one-cycle pulse at the end of every frame
- cmd_error  output  1  sticky protocol-error flag; cleared only by reset

Behaviour:
- Synchronization
  - All three serial inputs pass through SYNC_STAGES flops, then an edge detector on the synchronized signals.
  - Events act SYNC_STAGES+1 clock cycles after the pad edge.
  - Required master timing: each sio_clk high or low phase is at least SYNC_STAGES+2 clock cycles.
- Serial format
  - Bytes are LSB first.
  - Receive: sample DIO on the sio_clk rising edge.
  - Transmit: drive DIO on the sio_clk falling edge.
- FSM states: IDLE, CMD, WRITE, READ, DROP.
- IDLE
  - sio_stb falling -> CMD; bit counter = 0.
- CMD: after the 8th rising edge, decode the byte.
  - 01xx_xxxx, data command:
    - bit 2 sets the fixed-address flag (0 = auto-increment).
    - bit 1 = 1 selects read: latch keys -> READ.
    - Bit 1 = 0 -> DROP; the data command carries no payload.
  - 10xx_xxxx, display control: display_on = bit 3, brightness = bits 2:0 -> DROP.
  - 11xx_xxxx, address set: addr = bits 3:0 -> WRITE.
  - 00xx_xxxx: set cmd_error -> DROP.
- WRITE
  - Each completed byte is written to ram[addr].
  - addr increments mod 16 (15 -> 0) unless the fixed-address flag is set.
- READ
  - Transmit byte k (k = 0..3) = {3'b0, keys_latched[k+4], 3'b0, keys_latched[k]}.
  - sio_dio_oe rises on the first sio_clk falling edge after the command byte, driving bit 0 of byte 0.
  - Each subsequent falling edge advances one bit.
  - After the 32nd bit has been held through its rising edge, the next falling edge drops oe.
  - Further clocks in the frame are ignored.
- DROP: ignore all clocks until sio_stb rises.
- Frame end
  - sio_stb rising in any non-IDLE state -> IDLE.
  - oe drops in the same cycle; frame_done pulses.
  - A partially received byte (bit counter != 0) is discarded and sets cmd_error.
  - Bytes already written stay written.
- Persistence across frames: addr, the fixed-address flag, RAM, display_on and brightness. The bit counter and keys_latched do not persist.
- sio_stb falling while not IDLE (glitch): restart CMD and set cmd_error.
- Reset values
  - All 16 RAM bytes = 0, addr = 0, auto-increment mode.
  - display_on = 0, brightness = 0.
  - sio_dio_oe = 0, sio_dio_out = 1, frame_done = 0, cmd_error = 0, FSM = IDLE.
  - Reset mid-frame forces IDLE immediately; the rest of that frame is seen from IDLE and ignored until the next sio_stb falling edge.
- Contention check: sio_dio_in is ignored while oe = 1.

Test Plan:
- Frame 0x40; frame 0xC0 followed by 16 bytes 0x00..0x0F -> ram[i] = i; cmd_error = 0; two frame_done pulses.
- Frame 0x44; frame 0xC5 followed by 0xAA, 0x55 -> ram[5] = 0x55, ram[6] unchanged. Then frame 0x40; frame 0xCF followed by 0x11, 0x22 -> ram[15] = 0x11, ram[0] = 0x22 (wrap).
- Frame 0x8C -> display_on = 1, brightness = 4. Frame 0x80 -> display_on = 0, brightness = 0.
- keys = 8'b1000_0101, frame 0x42 with 32 read clocks -> master receives bytes 0x01, 0x00, 0x01, 0x10; oe high only during the read bits; keys changed mid-read have no effect.
- Frame 0xC3 followed by 5 bits then sio_stb high -> ram[3] unchanged, cmd_error = 1. Frame 0x12 -> ignored, cmd_error stays 1.
- reset_n low mid-read with oe = 1 -> oe = 0 asynchronously, RAM cleared. The next clean 0x42 frame reads correctly.

Source files
------------

// File: rtl/tm1638_responder_if.sv
// Serial STB/CLK/DIO link between a TM1638 master and the responder model.
interface tm1638_responder_if;
    logic sio_clk;
    logic sio_stb;
    logic sio_dio_in;
    logic sio_dio_out;
    logic sio_dio_oe;

    modport master (
        output sio_clk,
        output sio_stb,
        output sio_dio_in,
        input  sio_dio_out,
        input  sio_dio_oe
    );

    modport slave (
        input  sio_clk,
        input  sio_stb,
        input  sio_dio_in,
        output sio_dio_out,
        output sio_dio_oe
    );
endinterface

// File: rtl/tm1638_responder.sv
// TM1638 device-side model: decodes the serial command stream, holds display RAM
// and display control, and returns key-scan bytes on read commands.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    tm1638_responder_if.slave    sio,
    input  logic [7:0]           keys,
    input  logic [3:0]           ram_addr,
    output logic [7:0]           ram_data,
    output logic                 display_on,
    output logic [2:0]           brightness,
    output logic                 frame_done,
    output logic                 cmd_error
);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WRITE, S_READ, S_DROP} state_t;

    // Key-scan bit for transmit index idx: bit 0 of a byte is key k, bit 4 is key k+4.
    function automatic logic tx_bit(input logic [7:0] kv, input logic [4:0] idx);
        logic b;
        case (idx[2:0])
            3'd0:    b = kv[{1'b0, idx[4:3]}];
            3'd4:    b = kv[{1'b1, idx[4:3]}];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [SYNC_STAGES-1:0] dio_sync_q, dio_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   stb_prev_q, stb_prev_d;
    logic                   clk_s, stb_s, dio_s;
    logic                   clk_rise_s, clk_fall_s, stb_rise_s, stb_fall_s;
    logic [7:0]             rx_byte_s;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shreg_q, shreg_d;
    logic [5:0] tx_cnt_q, tx_cnt_d;
    logic [7:0] keys_lat_q, keys_lat_d;
    logic [3:0] addr_q, addr_d;
    logic       fixed_q, fixed_d;
    logic       disp_on_q, disp_on_d;
    logic [2:0] bright_q, bright_d;
    logic       oe_q, oe_d;
    logic       dout_q, dout_d;
    logic       frame_done_q, frame_done_d;
    logic       cmd_error_q, cmd_error_d;
    logic [7:0] ram_q [16];
    logic [7:0] ram_d [16];

    // Synchronizer shift and edge-detect history.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], sio.sio_clk};
        stb_sync_d = {stb_sync_q[SYNC_STAGES-2:0], sio.sio_stb};
        dio_sync_d = {dio_sync_q[SYNC_STAGES-2:0], sio.sio_dio_in};
        clk_prev_d = clk_s;
        stb_prev_d = stb_s;
    end

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign stb_s      = stb_sync_q[SYNC_STAGES-1];
    assign dio_s      = dio_sync_q[SYNC_STAGES-1];
    assign clk_rise_s = clk_s & ~clk_prev_q;
    assign clk_fall_s = ~clk_s & clk_prev_q;
    assign stb_rise_s = stb_s & ~stb_prev_q;
    assign stb_fall_s = ~stb_s & stb_prev_q;
    assign rx_byte_s  = {dio_s, shreg_q};

    // Frame FSM: strobe edges take priority over clock edges.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        tx_cnt_d     = tx_cnt_q;
        keys_lat_d   = keys_lat_q;
        addr_d       = addr_q;
        fixed_d      = fixed_q;
        disp_on_d    = disp_on_q;
        bright_d     = bright_q;
        oe_d         = oe_q;
        dout_d       = dout_q;
        frame_done_d = 1'b0;
        cmd_error_d  = cmd_error_q;
        ram_d        = ram_q;
        if (stb_fall_s) begin
            state_d     = S_CMD;
            bit_cnt_d   = 3'd0;
            oe_d        = 1'b0;
            dout_d      = 1'b1;
            cmd_error_d = cmd_error_q | (state_q != S_IDLE);
        end else if (stb_rise_s && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            bit_cnt_d    = 3'd0;
            oe_d         = 1'b0;
            dout_d       = 1'b1;
            frame_done_d = 1'b1;
            cmd_error_d  = cmd_error_q | (bit_cnt_q != 3'd0);
        end else begin
            case (state_q)
                S_CMD, S_WRITE: begin
                    if (clk_rise_s && !oe_q) begin
                        shreg_d   = rx_byte_s[7:1];
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q != 3'd7) begin
                            state_d = state_q;
                        end else if (state_q == S_WRITE) begin
                            ram_d[addr_q] = rx_byte_s;
                            addr_d        = fixed_q ? addr_q : addr_q + 4'd1;
                        end else begin
                            case (rx_byte_s[7:6])
                                2'b01: begin
                                    fixed_d = rx_byte_s[2];
                                    if (rx_byte_s[1]) begin
                                        keys_lat_d = keys;
                                        tx_cnt_d   = 6'd0;
                                        state_d    = S_READ;
                                    end else begin
                                        state_d = S_DROP;
                                    end
                                end
                                2'b10: begin
                                    disp_on_d = rx_byte_s[3];
                                    bright_d  = rx_byte_s[2:0];
                                    state_d   = S_DROP;
                                end
                                2'b11: begin
                                    addr_d  = rx_byte_s[3:0];
                                    state_d = S_WRITE;
                                end
                                default: begin
                                    cmd_error_d = 1'b1;
                                    state_d     = S_DROP;
                                end
                            endcase
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                S_READ: begin
                    // 32 bits out, one extra falling edge to release DIO, then idle until STB.
                    if (clk_fall_s && (tx_cnt_q < 6'd32)) begin
                        oe_d     = 1'b1;
                        dout_d   = tx_bit(keys_lat_q, tx_cnt_q[4:0]);
                        tx_cnt_d = tx_cnt_q + 6'd1;
                    end else if (clk_fall_s && (tx_cnt_q == 6'd32)) begin
                        oe_d     = 1'b0;
                        dout_d   = 1'b1;
                        tx_cnt_d = 6'd33;
                    end else begin
                        tx_cnt_d = tx_cnt_q;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State registers; STB history resets low so a frame already in progress at reset release is not seen as a new one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= {SYNC_STAGES{1'b1}};
            stb_sync_q   <= {SYNC_STAGES{1'b0}};
            dio_sync_q   <= {SYNC_STAGES{1'b1}};
            clk_prev_q   <= 1'b1;
            stb_prev_q   <= 1'b0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= 3'd0;
            shreg_q      <= 7'd0;
            tx_cnt_q     <= 6'd0;
            keys_lat_q   <= 8'h00;
            addr_q       <= 4'd0;
            fixed_q      <= 1'b0;
            disp_on_q    <= 1'b0;
            bright_q     <= 3'd0;
            oe_q         <= 1'b0;
            dout_q       <= 1'b1;
            frame_done_q <= 1'b0;
            cmd_error_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                ram_q[i] <= 8'h00;
            end
        end else begin
            clk_sync_q   <= clk_sync_d;
            stb_sync_q   <= stb_sync_d;
            dio_sync_q   <= dio_sync_d;
            clk_prev_q   <= clk_prev_d;
            stb_prev_q   <= stb_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            tx_cnt_q     <= tx_cnt_d;
            keys_lat_q   <= keys_lat_d;
            addr_q       <= addr_d;
            fixed_q      <= fixed_d;
            disp_on_q    <= disp_on_d;
            bright_q     <= bright_d;
            oe_q         <= oe_d;
            dout_q       <= dout_d;
            frame_done_q <= frame_done_d;
            cmd_error_q  <= cmd_error_d;
            ram_q        <= ram_d;
        end
    end

    assign sio.sio_dio_out = dout_q;
    assign sio.sio_dio_oe  = oe_q;
    assign ram_data        = ram_q[ram_addr];
    assign display_on      = disp_on_q;
    assign brightness      = bright_q;
    assign frame_done      = frame_done_q;
    assign cmd_error       = cmd_error_q;

endmodule

// File: tb/tb_tm1638_responder.sv
// Randomized bench for tm1638_responder: drives frames as a TM1638 master and
// compares RAM, control, key bytes and flags against a frame-level model.
module tb_tm1638_responder;
    localparam int SS = 2;
    localparam int PH = 6;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       mdio = 1'b1;
    logic [7:0] keys = 8'h00;
    logic [3:0] ram_addr = 4'd0;
    logic [7:0] ram_data;
    logic       display_on;
    logic [2:0] brightness;
    logic       frame_done;
    logic       cmd_error;

    tm1638_responder_if sio ();

    assign sio.sio_dio_in = sio.sio_dio_oe ? sio.sio_dio_out : mdio;

    tm1638_responder #(.SYNC_STAGES(SS)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .sio        (sio),
        .keys       (keys),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .display_on (display_on),
        .brightness (brightness),
        .frame_done (frame_done),
        .cmd_error  (cmd_error)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;
    int fd_cnt = 0;
    int fd_exp = 0;

    always @(negedge clock) begin
        if (frame_done) fd_cnt++;
    end

    // Reference model state.
    logic [7:0] m_ram [16];
    logic [3:0] m_addr;
    logic       m_fixed;
    logic       m_disp;
    logic [2:0] m_bright;
    logic       m_err;
    logic [7:0] txq [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
        m_addr = 4'd0; m_fixed = 1'b0; m_disp = 1'b0; m_bright = 3'd0; m_err = 1'b0;
    endtask

    function automatic logic [7:0] key_byte(input logic [7:0] kv, input int k);
        int v;
        v = ((int'(kv) >> k) & 1) + (((int'(kv) >> (k + 4)) & 1) * 16);
        return v[7:0];
    endfunction

    task automatic check_state(input string tag);
        check_eq({tag, ".display_on"}, {31'd0, display_on}, {31'd0, m_disp});
        check_eq({tag, ".brightness"}, {29'd0, brightness}, {29'd0, m_bright});
        check_eq({tag, ".cmd_error"}, {31'd0, cmd_error}, {31'd0, m_err});
        for (int i = 0; i < 16; i++) begin
            ram_addr = 4'(i);
            #1;
            check_eq($sformatf("%s.ram[%0d]", tag, i), {24'd0, ram_data}, {24'd0, m_ram[i]});
        end
    endtask

    task automatic send_bit(input logic b);
        sio.sio_clk = 1'b0; mdio = b; tick(PH);
        sio.sio_clk = 1'b1; tick(PH);
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
    endtask

    task automatic frame_begin();
        sio.sio_stb = 1'b0; tick(PH);
    endtask

    task automatic frame_end(input string tag);
        sio.sio_stb = 1'b1; tick(PH);
        fd_exp++;
        check_eq({tag, ".frame_done"}, fd_cnt, fd_exp);
        tick(PH);
    endtask

    // Sends txq as one frame, plus `partial` trailing bits, and updates the model.
    task automatic write_frame(input string tag, input int partial);
        logic [7:0] cmd;
        cmd = txq[0];
        frame_begin();
        foreach (txq[i]) send_byte(txq[i]);
        for (int i = 0; i < partial; i++) send_bit(1'($urandom_range(0, 1)));
        mdio = 1'b1;
        frame_end(tag);
        case (cmd[7:6])
            2'b01: m_fixed = cmd[2];
            2'b10: begin m_disp = cmd[3]; m_bright = cmd[2:0]; end
            2'b11: begin
                m_addr = cmd[3:0];
                for (int i = 1; i < txq.size(); i++) begin
                    m_ram[m_addr] = txq[i];
                    if (!m_fixed) m_addr = m_addr + 4'd1;
                end
                if (partial > 0) m_err = 1'b1;
            end
            default: m_err = 1'b1;
        endcase
        check_state(tag);
    endtask

    task automatic read_frame(input string tag, input logic [7:0] cmd, input bit change_keys);
        logic [7:0] lat;
        logic [7:0] rb;
        logic       oe_ok;
        lat = keys;
        m_fixed = cmd[2];
        frame_begin();
        send_byte(cmd);
        mdio = 1'b1;
        check_eq({tag, ".oe_before"}, {31'd0, sio.sio_dio_oe}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            oe_ok = 1'b1;
            for (int b = 0; b < 8; b++) begin
                sio.sio_clk = 1'b0; tick(PH);
                oe_ok = oe_ok & sio.sio_dio_oe;
                rb[b] = sio.sio_dio_in;
                sio.sio_clk = 1'b1; tick(PH);
            end
            check_eq($sformatf("%s.byte%0d", tag, k), {24'd0, rb}, {24'd0, key_byte(lat, k)});
            check_eq($sformatf("%s.oe%0d", tag, k), {31'd0, oe_ok}, 32'd1);
            if (change_keys && k == 0) keys = ~lat;
        end
        sio.sio_clk = 1'b0; tick(PH);
        check_eq({tag, ".oe_after"}, {31'd0, sio.sio_dio_oe}, 32'd0);
        sio.sio_clk = 1'b1; tick(PH);
        frame_end(tag);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] cmd;
        int         r;
        int         n;
        sio.sio_clk = 1'b1;
        sio.sio_stb = 1'b1;
        model_reset();
        tick(3);
        reset_n = 1'b1;
        tick(4);
        check_eq("reset.oe", {31'd0, sio.sio_dio_oe}, 32'd0);
        check_eq("reset.dout", {31'd0, sio.sio_dio_out}, 32'd1);
        check_eq("reset.frame_done", fd_cnt, 32'd0);
        check_state("reset");

        // Auto-increment fill of all 16 bytes.
        txq = {8'h40}; write_frame("dcmd40", 0);
        txq = {8'hC0};
        for (int i = 0; i < 16; i++) txq.push_back(8'(i));
        write_frame("fill", 0);

        // Fixed address, then auto-increment across the 15 -> 0 wrap.
        txq = {8'h44}; write_frame("dcmd44", 0);
        txq = {8'hC5, 8'hAA, 8'h55}; write_frame("fixed", 0);
        txq = {8'h40}; write_frame("dcmd40b", 0);
        txq = {8'hCF, 8'h11, 8'h22}; write_frame("wrap", 0);

        txq = {8'h8C}; write_frame("disp8c", 0);
        txq = {8'h80}; write_frame("disp80", 0);

        keys = 8'b1000_0101;
        read_frame("read85", 8'h42, 1'b1);

        // Randomized legal traffic.
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 3);
            case (r)
                0: begin txq = {8'h40 | (8'($urandom_range(0, 1)) << 2)}; write_frame("rnd_dcmd", 0); end
                1: begin txq = {8'h80 | 8'($urandom_range(0, 15))}; write_frame("rnd_disp", 0); end
                2: begin
                    txq = {8'hC0 | 8'($urandom_range(0, 15))};
                    n = $urandom_range(1, 5);
                    for (int i = 0; i < n; i++) txq.push_back(8'($urandom));
                    write_frame("rnd_write", 0);
                end
                default: begin
                    keys = 8'($urandom);
                    cmd = 8'h42 | (8'($urandom_range(0, 1)) << 2);
                    read_frame("rnd_read", cmd, 1'($urandom_range(0, 1)));
                end
            endcase
        end

        // Truncated byte, then an illegal command.
        txq = {8'hC3}; write_frame("partial", 5);
        txq = {8'h12}; write_frame("illegal", 0);

        // Reset in the middle of a read with DIO driven.
        keys = 8'($urandom);
        frame_begin();
        send_byte(8'h42);
        for (int b = 0; b < 10; b++) send_bit(1'b1);
        sio.sio_clk = 1'b0; tick(PH);
        check_eq("midreset.oe_pre", {31'd0, sio.sio_dio_oe}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("midreset.oe_async", {31'd0, sio.sio_dio_oe}, 32'd0);
        model_reset();
        tick(2);
        reset_n = 1'b1;
        sio.sio_clk = 1'b1; tick(PH);
        for (int b = 0; b < 6; b++) send_bit(1'b1);
        sio.sio_stb = 1'b1; tick(2 * PH);
        check_eq("midreset.frame_done", fd_cnt, fd_exp);
        check_state("midreset");

        keys = 8'($urandom);
        read_frame("post_reset_read", 8'h42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end
endmodule
